// File: rtl/subsurf_pkg.sv
// Shared types and constants for the subdivision engine I/O sequencer.
package subsurf_pkg;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 512;
  localparam logic [3:0] WE_ALL = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAITB,
    RUN,
    DRAIN,
    FIN
  } mesh_io_state_t;

endpackage

// File: rtl/mesh_io_if.sv
// Host-facing mesh input stream and result output stream, both valid/ready.
interface mesh_io_if;
  import subsurf_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/mesh_io_skid.sv
// Two-entry FIFO between the RAM2 read pipeline and the output stream.
// The occupancy count lets the reader issue only reads that are guaranteed a slot.
module mesh_io_skid #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic [1:0]    count
);

  logic [1:0][DW-1:0] data_q;
  logic [1:0]         last_q;
  logic               wp;
  logic               rp;
  logic [1:0]         cnt;
  logic               push;
  logic               pop;

  assign push     = wr_valid;
  assign pop      = rd_valid && rd_ready;
  assign rd_valid = (cnt != 2'd0);
  assign rd_data  = data_q[rp];
  assign rd_last  = rd_valid && last_q[rp];
  assign count    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      last_q <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        data_q[wp] <= wr_data;
        last_q[wp] <= wr_last;
        wp         <= ~wp;
      end
      if (pop) begin
        rp <= ~rp;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mesh_io.sv
// Host-side I/O sequencer: loads the mesh into RAM0, kicks subsurf, waits for it,
// then streams the result words out of RAM2.
module mesh_io #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int BUSY_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mesh_io_if.slave          io,
  input  logic [ADDR_W:0]   out_len,
  output logic              start,
  input  logic              busy,
  output logic              en0,
  output logic [3:0]        we0,
  output logic [ADDR_W-1:0] a0,
  output logic [DATA_W-1:0] di0,
  output logic              en2,
  output logic [ADDR_W-1:0] a2,
  input  logic [DATA_W-1:0] do2,
  output logic              mem_own,
  output logic              done,
  output logic              ovf
);

  import subsurf_pkg::*;

  mesh_io_state_t    state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   rcnt;
  logic [7:0]        wcnt;
  logic              rv;
  logic              rv_last;
  logic [1:0]        fcount;
  logic              wr;
  logic              pop;
  logic              issue;
  logic              last_rd;

  assign wr  = io.in_valid && io.in_ready;
  assign en0 = wr;
  assign we0 = wr ? WE_ALL : 4'h0;
  assign a0  = wr ? wptr : '0;
  assign di0 = wr ? io.in_data : '0;

  // A read may issue only if buffered words plus the one in flight, net of a pop, leave a slot.
  assign pop     = io.out_valid && io.out_ready;
  assign issue   = (state == DRAIN) && (rcnt < len) &&
                   (({1'b0, fcount} + {2'b0, rv}) < (3'd2 + {2'b0, pop}));
  assign last_rd = (rcnt == len - (ADDR_W+1)'(1));
  assign en2     = issue;
  assign a2      = issue ? rcnt[ADDR_W-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv      <= 1'b0;
      rv_last <= 1'b0;
    end else begin
      rv      <= issue;
      rv_last <= issue && last_rd;
    end
  end

  mesh_io_skid #(.DW(DATA_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (rv),
    .wr_data  (do2),
    .wr_last  (rv_last),
    .rd_valid (io.out_valid),
    .rd_ready (io.out_ready),
    .rd_data  (io.out_data),
    .rd_last  (io.out_last),
    .count    (fcount)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      io.in_ready <= 1'b0;
      start       <= 1'b0;
      mem_own     <= 1'b1;
      done        <= 1'b0;
      ovf         <= 1'b0;
      wptr        <= '0;
      len         <= '0;
      rcnt        <= '0;
      wcnt        <= '0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          io.in_ready <= 1'b1;
          mem_own     <= 1'b1;
          if (wr) begin
            ovf  <= 1'b0;
            wptr <= ADDR_W'(1);
            if (io.in_last) begin
              state       <= KICK;
              io.in_ready <= 1'b0;
              start       <= 1'b1;
              mem_own     <= 1'b0;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (wr) begin
            wptr <= wptr + ADDR_W'(1);
            // The top address without a last marker ends the load as an overflow.
            if (io.in_last || (wptr == ADDR_W'(MEM_WORDS - 1))) begin
              ovf         <= !io.in_last;
              state       <= KICK;
              io.in_ready <= 1'b0;
              start       <= 1'b1;
              mem_own     <= 1'b0;
            end
          end
        end
        KICK: begin
          state <= WAITB;
          wptr  <= '0;
          wcnt  <= '0;
        end
        WAITB: begin
          if (busy) begin
            state <= RUN;
          end else if (wcnt == 8'(BUSY_WAIT - 2)) begin
            state   <= DRAIN;
            len     <= out_len;
            rcnt    <= '0;
            mem_own <= 1'b1;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        RUN: begin
          if (!busy) begin
            state   <= DRAIN;
            len     <= out_len;
            rcnt    <= '0;
            mem_own <= 1'b1;
          end
        end
        DRAIN: begin
          if (issue) begin
            rcnt <= rcnt + (ADDR_W+1)'(1);
          end
          if ((len == '0) || (pop && io.out_last)) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state       <= IDLE;
          io.in_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_io.sv
// Scoreboard bench for mesh_io: RAM and busy models, queued expected output words,
// and a negedge monitor that checks the streams and protocol timing.
module tb_mesh_io;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int BW  = 8;
  localparam int MEM = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   out_len;
  logic          start, busy, en0, en2, mem_own, done, ovf;
  logic [3:0]    we0;
  logic [AW-1:0] a0, a2;
  logic [DW-1:0] di0, do2;

  mesh_io_if bus();

  mesh_io #(.ADDR_W(AW), .DATA_W(DW), .BUSY_WAIT(BW)) dut (
    .clk(clk), .rst_n(rst_n), .io(bus), .out_len(out_len), .start(start), .busy(busy),
    .en0(en0), .we0(we0), .a0(a0), .di0(di0), .en2(en2), .a2(a2), .do2(do2),
    .mem_own(mem_own), .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram0 [MEM];
  logic [DW-1:0] ram2 [MEM];
  logic [DW-1:0] sendData [MEM+8];
  logic [32:0]   expQ [$];
  int nChecks = 0, nPass = 0, cyc = 0;
  int busyLen = 0, readyMode = 0;
  int startCnt, doneCnt, writes, outBeats;
  int startCyc, lastBeatCyc, drainCyc, firstValidCyc, busyFallCyc;
  logic [5:0] readyPat = 6'b101001;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (en2) do2 <= ram2[a2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // subsurf stand-in: busy rises two cycles after start and holds for busyLen cycles.
  initial begin
    int bDelay = 0, bLeft = 0;
    busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin busy = 1'b0; bDelay = 0; bLeft = 0; end
      else if (start) begin bDelay = 2; busy = 1'b0; end
      else if (bDelay > 0) begin
        bDelay--;
        if (bDelay == 0 && busyLen > 0) begin busy = 1'b1; bLeft = busyLen; end
      end else if (bLeft > 0) begin
        bLeft--;
        if (bLeft == 0) busy = 1'b0;
      end
    end
  end

  initial begin
    int rIdx = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = readyPat[rIdx % 6];
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      rIdx++;
    end
  end

  initial begin
    logic prevStall = 1'b0, prevBusy = 1'b0, prevOwn = 1'b1, prevLast = 1'b0;
    logic [DW-1:0] prevData = '0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevStall = 1'b0; prevBusy = 1'b0; prevOwn = 1'b1;
      end else begin
        if (en0 && we0 == 4'hF) begin ram0[a0] = di0; writes++; end
        if (bus.in_valid && bus.in_ready) lastBeatCyc = cyc;
        if (start) begin startCnt++; startCyc = cyc; end
        if (done) doneCnt++;
        if (prevBusy && !busy) busyFallCyc = cyc;
        if (mem_own && !prevOwn && startCnt > 0 && drainCyc < 0) drainCyc = cyc;
        if (bus.out_valid) begin
          if (firstValidCyc < 0) firstValidCyc = cyc;
          if (prevStall) begin
            checkOutput("stall_data", bus.out_data, prevData);
            checkOutput("stall_last", bus.out_last, prevLast);
          end
          if (bus.out_ready) begin
            outBeats++;
            if (expQ.size() == 0) begin
              nChecks++;
              $display("[TB] FAIL extra_word: got %0h, expected no word", bus.out_data);
            end else begin
              e = expQ.pop_front();
              checkOutput("out_data", bus.out_data, e[31:0]);
              checkOutput("out_last", bus.out_last, e[32]);
            end
          end
        end
        prevStall = bus.out_valid && !bus.out_ready;
        prevData  = bus.out_data;
        prevLast  = bus.out_last;
        prevBusy  = busy;
        prevOwn   = mem_own;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last word is presented.
  task automatic applyStimulus(input int n, input bit withLast);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = sendData[i];
      bus.in_last  = withLast && (i == n - 1);
      if (i >= MEM) begin
        repeat (3) begin @(negedge clk); checkOutput("in_ready_ovf", bus.in_ready, 0); end
        @(posedge clk); #1;
      end else begin
        automatic bit accepted = 1'b0;
        automatic int g = 0;
        while (!accepted && g < 200) begin
          @(negedge clk); accepted = bus.in_ready;
          @(posedge clk); #1; g++;
        end
        if (!accepted) begin
          nChecks++;
          $display("[TB] FAIL in_accept: got no handshake, expected word %0d accepted", i);
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic runTest(input int n, input bit withLast, input int bLen, input int oLen,
                         input int rMode, input bit expOvf);
    int nw;
    @(posedge clk); #1;
    busyLen = bLen; readyMode = rMode; out_len = (AW+1)'(oLen);
    startCnt = 0; doneCnt = 0; writes = 0; outBeats = 0;
    startCyc = -1; lastBeatCyc = -1; drainCyc = -1; firstValidCyc = -1; busyFallCyc = -1;
    for (int i = 0; i < MEM; i++) ram0[i] = 32'hDEAD_BEEF;
    for (int i = 0; i < oLen; i++) expQ.push_back({1'(i == oLen - 1), ram2[i]});
    applyStimulus(n, withLast);
    for (int g = 0; g < 4000 && doneCnt == 0; g++) @(negedge clk);
    repeat (3) @(negedge clk);
    nw = (n > MEM) ? MEM : n;
    checkOutput("done_count", doneCnt, 1);
    checkOutput("start_count", startCnt, 1);
    checkOutput("start_after_last_beat", startCyc - lastBeatCyc, 1);
    checkOutput("words_left", expQ.size(), 0);
    checkOutput("out_beats", outBeats, oLen);
    checkOutput("ovf", ovf, expOvf);
    checkOutput("ram0_writes", writes, nw);
    for (int i = 0; i < nw; i++) checkOutput("ram0_word", ram0[i], sendData[i]);
    if (bLen == 0) checkOutput("waitb_timeout", drainCyc - startCyc, BW);
    else checkOutput("drain_after_busy", drainCyc - busyFallCyc, 1);
    if (oLen > 0) checkOutput("drain_latency", firstValidCyc - drainCyc, 2);
    expQ.delete();
  endtask

  task automatic fillRandom(input int n, input int oLen);
    for (int i = 0; i < n; i++) sendData[i] = $urandom;
    for (int i = 0; i < oLen; i++) ram2[i] = $urandom;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    out_len = '0;
    for (int i = 0; i < MEM; i++) ram2[i] = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_mem_own", mem_own, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovf", ovf, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); checkOutput("in_ready_pre_edge", bus.in_ready, 0);
    @(negedge clk); checkOutput("in_ready_after_release", bus.in_ready, 1);

    for (int i = 0; i < 4; i++) sendData[i] = 32'h11 * (i + 1);
    for (int i = 0; i < 3; i++) ram2[i] = 32'hA0 + i;
    runTest(4, 1'b1, 20, 3, 0, 1'b0);
    runTest(4, 1'b1, 20, 3, 1, 1'b0);

    fillRandom(MEM + 1, 4);
    runTest(MEM + 1, 1'b0, 5, 4, 2, 1'b1);

    fillRandom(3, 0);
    runTest(3, 1'b1, 0, 0, 0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      automatic int n = $urandom_range(1, 40);
      automatic int o = $urandom_range(1, 60);
      fillRandom(n, o);
      runTest(n, 1'b1, $urandom_range(1, 10), o, 2, 1'b0);
    end

    // Abort a run with reset while subsurf is busy, then check a fresh one-word job.
    fillRandom(2, 3);
    busyLen = 40; out_len = 10'd3;
    @(posedge clk); #1;
    applyStimulus(2, 1'b1);
    for (int g = 0; g < 100 && !busy; g++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_in_ready", bus.in_ready, 0);
    checkOutput("mid_rst_out_valid", bus.out_valid, 0);
    checkOutput("mid_rst_out_last", bus.out_last, 0);
    checkOutput("mid_rst_out_data", bus.out_data, 0);
    checkOutput("mid_rst_start", start, 0);
    checkOutput("mid_rst_en0_we0", {en0, we0}, 0);
    checkOutput("mid_rst_a0_di0", {a0, di0}, 0);
    checkOutput("mid_rst_en2_a2", {en2, a2}, 0);
    checkOutput("mid_rst_mem_own", mem_own, 1);
    checkOutput("mid_rst_done_ovf", {done, ovf}, 0);
    expQ.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    fillRandom(1, 2);
    runTest(1, 1'b1, 3, 2, 0, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
